serial_paralelo: RTL and testbench

- Receive-side deserializer for the PCI physical-layer serial link.
- Samples the 1-bit line at clk_32f, MSB first, and finds byte alignment on the idle comma 0xBC.
- Declares the link active after BC_COUNT consecutive aligned commas.
- Presents recovered 8-bit words with a valid flag; commas are reported as idle (valid low).

---
 rtl/pci_phy_pkg.sv | 14 +
 rtl/serial_paralelo_comma_detect.sv | 12 +
 rtl/serial_paralelo.sv | 107 ++++++++++
 tb/tb_serial_paralelo.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pci_phy_pkg.sv
// Shared constants and types for the PCI physical-layer serial link.
// Both the transmitter and the receive deserializer use the same comma symbol.
package pci_phy_pkg;

  localparam logic [7:0]  COMMA_BC     = 8'hBC;
  localparam int unsigned BC_COUNT_DEF = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } link_state_e;

endpackage

// File: rtl/serial_paralelo_comma_detect.sv
// Combinational idle-comma compare.
// Kept separate so a later 8b lane checker can reuse it.
module serial_paralelo_comma_detect
  import pci_phy_pkg::*;
(
  input  logic [7:0] word,
  output logic       is_comma
);

  assign is_comma = (word == COMMA_BC);

endmodule

// File: rtl/serial_paralelo.sv
// Receive-side deserializer: finds byte alignment on the 0xBC comma,
// qualifies the link after BC_COUNT aligned commas, then emits payload bytes.
module serial_paralelo
  import pci_phy_pkg::*;
#(
  parameter int unsigned BC_COUNT = BC_COUNT_DEF  // legal range 1..15
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_serial_paralelo,
  output logic       valid_out,
  output logic       active
);

  localparam logic [3:0] BC_TARGET = 4'(BC_COUNT);

  // Only the 7 most recent bits are needed: the 8th comes straight from data_in.
  logic [6:0]  sr;
  logic [7:0]  word;
  logic        is_comma;
  logic        boundary;

  link_state_e state, state_nx;
  logic [2:0]  bit_cnt, bit_cnt_nx;
  logic [3:0]  bc_cnt, bc_cnt_nx;
  logic [7:0]  data_nx;
  logic        valid_nx;

  assign word     = {sr, data_in};
  assign boundary = (bit_cnt == 3'd7);
  assign active   = (state == ACTIVE);

  serial_paralelo_comma_detect u_comma_detect (
    .word     (word),
    .is_comma (is_comma)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    bc_cnt_nx  = bc_cnt;
    data_nx    = data_serial_paralelo;
    valid_nx   = valid_out;

    unique case (state)
      SEARCH: begin
        if (is_comma) begin
          bit_cnt_nx = 3'd0;
          bc_cnt_nx  = 4'd1;
          state_nx   = (BC_TARGET == 4'd1) ? ACTIVE : ALIGN;
        end
      end

      ALIGN: begin
        bit_cnt_nx = bit_cnt + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            bc_cnt_nx = bc_cnt + 4'd1;
            if (bc_cnt + 4'd1 == BC_TARGET) state_nx = ACTIVE;
          end else begin
            bc_cnt_nx = 4'd0;
            state_nx  = SEARCH;
          end
        end
      end

      ACTIVE: begin
        // Sticky: alignment is never re-checked once qualified.
        bit_cnt_nx = bit_cnt + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            valid_nx = 1'b0;
          end else begin
            data_nx  = word;
            valid_nx = 1'b1;
          end
        end
      end

      default: state_nx = SEARCH;
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sr                   <= '0;
      state                <= SEARCH;
      bit_cnt              <= '0;
      bc_cnt               <= '0;
      data_serial_paralelo <= '0;
      valid_out            <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      sr                   <= word[6:0];
      state                <= state_nx;
      bit_cnt              <= bit_cnt_nx;
      bc_cnt               <= bc_cnt_nx;
      data_serial_paralelo <= data_nx;
      valid_out            <= valid_nx;
    end
  end

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed bench for serial_paralelo: alignment, qualification, idle handling,
// async reset and the single-comma qualification variant.
module tb_serial_paralelo;
  import pci_phy_pkg::*;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       data_in;

  logic [7:0] d4_data;
  logic       d4_valid;
  logic       d4_active;
  logic [7:0] d1_data;
  logic       d1_valid;
  logic       d1_active;

  int total = 0;
  int bad   = 0;

  always #5 clk_32f = ~clk_32f;

  serial_paralelo #(.BC_COUNT(4)) dut4 (
    .clk_32f              (clk_32f),
    .reset                (reset),
    .data_in              (data_in),
    .data_serial_paralelo (d4_data),
    .valid_out            (d4_valid),
    .active               (d4_active)
  );

  serial_paralelo #(.BC_COUNT(1)) dut1 (
    .clk_32f              (clk_32f),
    .reset                (reset),
    .data_in              (data_in),
    .data_serial_paralelo (d1_data),
    .valid_out            (d1_valid),
    .active               (d1_active)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives bits b[hi] down to b[lo]; returns #1 after the edge that sampled the last one.
  task automatic send_bits(input logic [7:0] b, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      @(negedge clk_32f);
      data_in = b[i];
      @(posedge clk_32f);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 7, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk_32f);
    reset   = 1'b0;
    data_in = 1'b0;
    #1;
    check({tag, "_data"},   d4_data,   8'h00);
    check({tag, "_valid"},  d4_valid,  8'h00);
    check({tag, "_active"}, d4_active, 8'h00);
    @(posedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    data_in = 1'b0;
    #1;
    check("por_data",    d4_data,   8'h00);
    check("por_valid",   d4_valid,  8'h00);
    check("por_active",  d4_active, 8'h00);
    check("por_active1", d1_active, 8'h00);
    repeat (2) @(posedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b1;

    // Aligned start
    for (int i = 0; i < 3; i++) begin
      send_byte(COMMA_BC);
      check($sformatf("al_comma%0d_active", i + 1), d4_active, 8'h00);
    end
    send_byte(COMMA_BC);
    check("al_comma4_active", d4_active, 8'h01);
    check("al_comma4_valid",  d4_valid,  8'h00);
    send_bits(8'hA5, 7, 1);
    check("al_a5_early_valid", d4_valid, 8'h00);
    send_bits(8'hA5, 0, 0);
    check("al_a5_data",  d4_data,  8'hA5);
    check("al_a5_valid", d4_valid, 8'h01);
    send_bits(8'h3C, 7, 4);
    check("al_3c_hold_data", d4_data, 8'hA5);
    send_bits(8'h3C, 3, 0);
    check("al_3c_data",  d4_data,  8'h3C);
    check("al_3c_valid", d4_valid, 8'h01);

    // Idle words while active
    send_byte(8'h77);
    check("idle_77_data",  d4_data,  8'h77);
    check("idle_77_valid", d4_valid, 8'h01);
    send_byte(COMMA_BC);
    check("idle_bc1_data",  d4_data,  8'h77);
    check("idle_bc1_valid", d4_valid, 8'h00);
    send_byte(COMMA_BC);
    check("idle_bc2_data",   d4_data,   8'h77);
    check("idle_bc2_valid",  d4_valid,  8'h00);
    check("idle_bc2_active", d4_active, 8'h01);
    send_byte(8'h88);
    check("idle_88_data",  d4_data,  8'h88);
    check("idle_88_valid", d4_valid, 8'h01);

    // Async reset at bit 3 of a payload byte
    send_bits(8'h55, 7, 5);
    #2;
    reset = 1'b0;
    #1;
    check("ar_data",   d4_data,   8'h00);
    check("ar_valid",  d4_valid,  8'h00);
    check("ar_active", d4_active, 8'h00);
    data_in = 1'b0;
    @(posedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_byte(COMMA_BC);
      check($sformatf("ar_comma%0d_active", i + 1), d4_active, 8'h00);
    end
    send_byte(COMMA_BC);
    check("ar_comma4_active", d4_active, 8'h01);
    send_byte(8'hC3);
    check("ar_c3_data",  d4_data,  8'hC3);
    check("ar_c3_valid", d4_valid, 8'h01);

    // Misaligned start: junk bits 1,1,0
    do_reset("ma_rst");
    send_bits(8'hC0, 7, 5);
    for (int i = 0; i < 3; i++) begin
      send_byte(COMMA_BC);
      check($sformatf("ma_comma%0d_active", i + 1), d4_active, 8'h00);
    end
    send_byte(COMMA_BC);
    check("ma_comma4_active", d4_active, 8'h01);
    send_byte(COMMA_BC);
    check("ma_comma5_valid", d4_valid, 8'h00);
    send_bits(8'h5A, 7, 1);
    check("ma_5a_early_valid", d4_valid, 8'h00);
    send_bits(8'h5A, 0, 0);
    check("ma_5a_data",  d4_data,  8'h5A);
    check("ma_5a_valid", d4_valid, 8'h01);

    // Broken qualification
    do_reset("bq_rst");
    send_byte(COMMA_BC);
    send_byte(COMMA_BC);
    send_byte(8'h3C);
    check("bq_3c_active", d4_active, 8'h00);
    check("bq_3c_valid",  d4_valid,  8'h00);
    for (int i = 0; i < 3; i++) begin
      send_byte(COMMA_BC);
      check($sformatf("bq_comma%0d_active", i + 1), d4_active, 8'h00);
    end
    send_byte(COMMA_BC);
    check("bq_comma4_active", d4_active, 8'h01);
    send_byte(8'h11);
    check("bq_11_data",  d4_data,  8'h11);
    check("bq_11_valid", d4_valid, 8'h01);

    // Single-comma qualification (BC_COUNT=1 instance)
    do_reset("one_rst");
    check("one_rst_active1", d1_active, 8'h00);
    send_byte(COMMA_BC);
    check("one_comma_active1", d1_active, 8'h01);
    check("one_comma_valid1",  d1_valid,  8'h00);
    check("one_comma_active4", d4_active, 8'h00);
    send_bits(8'h96, 7, 1);
    check("one_96_early_valid1", d1_valid, 8'h00);
    send_bits(8'h96, 0, 0);
    check("one_96_data1",  d1_data,  8'h96);
    check("one_96_valid1", d1_valid, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
